demux8_stream: RTL and testbench

- 1-to-8 stream demultiplexer. Routes each accepted input word to one of eight output channels selected by a 4-bit select.
- Each output channel has a one-entry registered buffer with valid/ready handshake, so a stalled channel blocks only traffic addressed to it.
- Sits on the distribution side of the 8:1 selection path and fans a shared producer out to eight consumers.

---
 rtl/demux8_stream_if.sv | 31 +++
 rtl/demux8_stream.sv | 94 +++++++++
 tb/tb_demux8_stream.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/demux8_stream_if.sv
// demux8_stream_if: bundles the shared producer handshake and the eight
// buffered consumer channels of the 1-to-8 stream demultiplexer.
//   in_valid/in_ready/in_data/in_sel : producer side handshake and routing
//   out0..out7, out_valid, out_ready : per-channel buffered data handshake
//   busy                             : OR of all out_valid bits
// slave modport is the demux view; master modport is the environment
// (producer plus consumers) view.
interface demux8_stream_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [3:0]       in_sel;
  logic [WIDTH-1:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [7:0]       out_valid;
  logic [7:0]       out_ready;
  logic             busy;

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out0, out1, out2, out3, out4, out5, out6, out7,
           out_valid, busy
  );

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out0, out1, out2, out3, out4, out5, out6, out7,
           out_valid, busy
  );
endinterface

// File: rtl/demux8_stream.sv
// demux8_stream: 1-to-8 stream demultiplexer. Each accepted input word is
// routed to one of eight channels, each owning a one-entry registered buffer,
// so a stalled channel only blocks traffic addressed to it.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : demux8_stream_if.slave (producer handshake + 8 output channels)

// One output channel: single-entry buffer. A load overrides a drain so a
// channel can accept a new word in the same cycle its consumer takes the old.
module demux8_lane #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);
  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (i_ready) begin
      // data left stale; it is don't-care while invalid
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
endmodule

module demux8_stream #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  demux8_stream_if.slave   bus
);
  localparam int NUM_LANES = 8;

  logic [2:0]                        w_dest;
  logic                              w_ready;
  logic                              w_accept;
  logic [NUM_LANES-1:0]              w_load;
  logic [NUM_LANES-1:0]              w_valid;
  logic [NUM_LANES-1:0][WIDTH-1:0]   w_data;

  // selects 7..15 all alias onto the last channel
  assign w_dest   = (bus.in_sel >= 4'd7) ? 3'd7 : bus.in_sel[2:0];
  // ready looks only at the addressed channel, never at in_valid
  assign w_ready  = ~w_valid[w_dest] | bus.out_ready[w_dest];
  assign w_accept = bus.in_valid & w_ready;

  genvar k;
  generate
    for (k = 0; k < NUM_LANES; k++) begin : g_lane
      assign w_load[k] = w_accept & (w_dest == 3'(k));

      demux8_lane #(.WIDTH(WIDTH)) u_lane (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load[k]),
        .i_data  (bus.in_data),
        .i_ready (bus.out_ready[k]),
        .o_data  (w_data[k]),
        .o_valid (w_valid[k])
      );
    end
  endgenerate

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = w_valid;
  // derived purely from the valid registers: no input-to-busy path
  assign bus.busy      = |w_valid;

  assign bus.out0 = w_data[0];
  assign bus.out1 = w_data[1];
  assign bus.out2 = w_data[2];
  assign bus.out3 = w_data[3];
  assign bus.out4 = w_data[4];
  assign bus.out5 = w_data[5];
  assign bus.out6 = w_data[6];
  assign bus.out7 = w_data[7];
endmodule

// File: tb/tb_demux8_stream.sv
// tb_demux8_stream: drives directed and random traffic into demux8_stream;
// a per-channel queue model of buffered words is compared every cycle.
module tb_demux8_stream;
  localparam int WIDTH = 32;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  demux8_stream_if #(.WIDTH(WIDTH)) bus ();

  demux8_stream #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference: each channel holds a queue of words currently buffered
  logic [WIDTH-1:0] mq [8][$];

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] outk(input int k);
    case (k)
      0: return bus.out0;
      1: return bus.out1;
      2: return bus.out2;
      3: return bus.out3;
      4: return bus.out4;
      5: return bus.out5;
      6: return bus.out6;
      default: return bus.out7;
    endcase
  endfunction

  // monitor: compare at the falling edge, then advance the model to what
  // the next rising edge should produce
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) mq[k].delete();
    end else begin
      logic [7:0] ev;
      int         d;
      logic       er;
      for (int k = 0; k < 8; k++) ev[k] = (mq[k].size() != 0);
      d  = (int'(bus.in_sel) > 6) ? 7 : int'(bus.in_sel);
      er = !ev[d] || bus.out_ready[d];
      chk("out_valid", WIDTH'(bus.out_valid), WIDTH'(ev));
      chk("busy", WIDTH'(bus.busy), WIDTH'(|ev));
      chk("in_ready", WIDTH'(bus.in_ready), WIDTH'(er));
      for (int k = 0; k < 8; k++)
        if (ev[k]) chk($sformatf("out%0d", k), outk(k), mq[k][0]);
      for (int k = 0; k < 8; k++)
        if (ev[k] && bus.out_ready[k]) void'(mq[k].pop_front());
      if (bus.in_valid && er) mq[d].push_back(bus.in_data);
    end
  end

  task automatic cyc(input logic v, input logic [3:0] sel,
                     input logic [WIDTH-1:0] data, input logic [7:0] ordy);
    bus.in_valid  = v;
    bus.in_sel    = sel;
    bus.in_data   = data;
    bus.out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, WIDTH'(bus.out_valid), '0);
    chk({tag, "_busy"}, WIDTH'(bus.busy), '0);
    for (int k = 0; k < 8; k++) chk($sformatf("%s_out%0d", tag, k), outk(k), '0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sel    = '0;
    bus.in_data   = '0;
    bus.out_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("por");
    rst_n = 1'b1;

    // basic route
    cyc(1'b1, 4'd3, 32'hA5A5_0003, 8'hFF);
    cyc(1'b0, 4'd0, 32'h0, 8'hFF);
    cyc(1'b0, 4'd0, 32'h0, 8'hFF);

    // select aliasing onto channel 7
    cyc(1'b1, 4'd7,  32'h7777_0007, 8'h80);
    cyc(1'b1, 4'd12, 32'h7777_000C, 8'h80);
    cyc(1'b1, 4'd15, 32'h7777_000F, 8'h80);
    cyc(1'b0, 4'd0,  32'h0, 8'h80);
    cyc(1'b0, 4'd0,  32'h0, 8'hFF);

    // backpressure isolation
    cyc(1'b1, 4'd2, 32'h2222_0001, 8'h00);
    cyc(1'b1, 4'd2, 32'h2222_0002, 8'h00);
    cyc(1'b1, 4'd2, 32'h2222_0002, 8'h00);
    cyc(1'b1, 4'd5, 32'h5555_0001, 8'h00);
    cyc(1'b1, 4'd2, 32'h2222_0002, 8'h04);
    cyc(1'b0, 4'd0, 32'h0, 8'h00);
    cyc(1'b0, 4'd0, 32'h0, 8'hFF);
    cyc(1'b0, 4'd0, 32'h0, 8'hFF);

    // full throughput
    for (int i = 0; i < 16; i++) cyc(1'b1, 4'(i % 8), $urandom, 8'hFF);
    cyc(1'b0, 4'd0, 32'h0, 8'hFF);

    // asynchronous reset with channels 0 and 2 held (out_valid=05)
    cyc(1'b1, 4'd0, 32'h0000_AAAA, 8'h00);
    cyc(1'b1, 4'd2, 32'h0002_BBBB, 8'h00);
    bus.in_valid = 1'b0;
    chk("pre_reset_out_valid", WIDTH'(bus.out_valid), WIDTH'(8'h05));
    #2 rst_n = 1'b0;
    #1 chk_reset_state("async");
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // reset while channel 6 is full and stalled with a pending word
    cyc(1'b1, 4'd6, 32'h6666_0001, 8'h00);
    cyc(1'b1, 4'd6, 32'h6666_0002, 8'h00);
    rst_n = 1'b0;
    #1 chk("stall_rst_v6", WIDTH'(bus.out_valid[6]), '0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post_rst_ready6", WIDTH'(bus.in_ready), WIDTH'(1'b1));
    cyc(1'b1, 4'd6, 32'h6666_0003, 8'h00);
    cyc(1'b0, 4'd0, 32'h0, 8'hFF);
    cyc(1'b0, 4'd0, 32'h0, 8'hFF);

    // randomized traffic with random backpressure and select changes
    for (int i = 0; i < 600; i++) begin
      logic [7:0] ordy;
      ordy = 8'($urandom) | 8'($urandom);
      if ((i / 100) % 2 == 1) ordy = 8'($urandom) & 8'($urandom);
      cyc(1'($urandom_range(0, 3) != 0), 4'($urandom), $urandom, ordy);
    end
    repeat (3) cyc(1'b0, 4'd0, 32'h0, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
